// File: rtl/aes_pkg.sv
// Shared AES definitions: block width, round counts per key size and the
// state encoding of the iterative round sequencer.
`ifndef AES_BLOCK_SIZE
`define AES_BLOCK_SIZE 128
`endif

package aes_pkg;

   localparam int AES_BLOCK_W = `AES_BLOCK_SIZE;

   localparam int AES_NR_128 = 10;
   localparam int AES_NR_192 = 12;
   localparam int AES_NR_256 = 14;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_ROUND,
      SEQ_DONE
   } aes_seq_state_t;

endpackage

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller. One block at a time is whitened with the first
// round key, then passed NR times through an external shared enc/dec round
// datapath, one round per clock. Round keys are fetched by index from an
// external combinational key store. The result is held until downstream
// accepts it; no new block is taken while a block is in flight or waiting.
module aes_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR     = AES_NR_128,
   parameter int KIDX_W = 4
) (
   input  logic                   Clk,
   input  logic                   Rst_n,
   input  logic                   In_valid,
   output logic                   In_ready,
   input  logic                   In_encrypt,
   input  logic [AES_BLOCK_W-1:0] In_block,
   output logic                   Out_valid,
   input  logic                   Out_ready,
   output logic [AES_BLOCK_W-1:0] Out_block,
   output logic [KIDX_W-1:0]      Key_idx,
   input  logic [AES_BLOCK_W-1:0] Key,
   output logic                   Rp_encrypt,
   output logic                   Rp_last,
   output logic [AES_BLOCK_W-1:0] Rp_key,
   output logic [AES_BLOCK_W-1:0] Rp_input_block,
   input  logic [AES_BLOCK_W-1:0] Rp_output_block
);

   localparam logic [KIDX_W-1:0] NR_IDX  = KIDX_W'(NR);
   localparam logic [KIDX_W-1:0] ONE_IDX = KIDX_W'(1);

   aes_seq_state_t         state;
   aes_seq_state_t         state_next;
   logic [AES_BLOCK_W-1:0] state_reg;
   logic [AES_BLOCK_W-1:0] out_block_reg;
   logic [KIDX_W-1:0]      round_cnt;
   logic                   mode_reg;
   logic                   out_valid_reg;
   logic                   in_fire;
   logic                   last_round;

   assign in_fire    = (state == SEQ_IDLE) && In_valid;
   assign last_round = (state == SEQ_ROUND) && (round_cnt == NR_IDX);

   // State register for the IDLE -> ROUND -> DONE control loop.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= SEQ_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state plus the combinational handshake and key-index outputs.
   // Decryption walks the key schedule backwards from NR down to 0.
   always_comb begin
      state_next = state;
      In_ready   = 1'b0;
      Key_idx    = '0;
      Rp_last    = 1'b0;
      case (state)
         SEQ_IDLE: begin
            In_ready = 1'b1;
            Key_idx  = In_encrypt ? '0 : NR_IDX;
            if (In_valid) begin
               state_next = SEQ_ROUND;
            end
         end
         SEQ_ROUND: begin
            Key_idx = mode_reg ? round_cnt : (NR_IDX - round_cnt);
            Rp_last = (round_cnt == NR_IDX);
            if (round_cnt == NR_IDX) begin
               state_next = SEQ_DONE;
            end
         end
         SEQ_DONE: begin
            if (out_valid_reg && Out_ready) begin
               state_next = SEQ_IDLE;
            end
         end
         default: begin
            state_next = SEQ_IDLE;
         end
      endcase
   end

   // Working state: initial AddRoundKey on accept, then one round result per
   // cycle. The round counter saturates at NR so it can never wrap.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg <= '0;
         mode_reg  <= 1'b0;
         round_cnt <= '0;
      end else begin
         if (in_fire) begin
            state_reg <= In_block ^ Key;
            mode_reg  <= In_encrypt;
            round_cnt <= ONE_IDX;
         end else if (state == SEQ_ROUND) begin
            state_reg <= Rp_output_block;
            if (round_cnt != NR_IDX) begin
               round_cnt <= round_cnt + ONE_IDX;
            end
         end
      end
   end

   // Registered result port: captured from the final round, held until taken.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         out_valid_reg <= 1'b0;
         out_block_reg <= '0;
      end else begin
         if (last_round) begin
            out_valid_reg <= 1'b1;
            out_block_reg <= Rp_output_block;
         end else if (out_valid_reg && Out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign Out_valid      = out_valid_reg;
   assign Out_block      = out_block_reg;
   assign Rp_encrypt     = mode_reg;
   assign Rp_key         = Key;
   assign Rp_input_block = state_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: an AES-128 (NR=10) and an AES-256 (NR=14)
// instance, each with a behavioural round port and key store built from a
// reference key schedule. FIPS-197 vectors plus back-pressure, back-to-back
// and mid-block reset sequences.
`timescale 1ns/1ps
module tb_aes_round_sequencer;
   import aes_pkg::*;

   localparam int NR_A = AES_NR_128;
   localparam int NR_B = AES_NR_256;
   localparam int KW   = 4;

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   logic         Clk = 1'b0;
   logic         Rst_n;
   logic         In_encrypt;
   logic [127:0] In_block;
   logic         Out_ready;
   logic         in_valid_a, in_valid_b;
   logic         cur_sel;

   logic         in_ready_a, out_valid_a, rp_enc_a, rp_last_a;
   logic [127:0] out_block_a, key_a, rp_key_a, rp_in_a, rp_out_a;
   logic [KW-1:0] key_idx_a;
   logic         in_ready_b, out_valid_b, rp_enc_b, rp_last_b;
   logic [127:0] out_block_b, key_b, rp_key_b, rp_in_b, rp_out_b;
   logic [KW-1:0] key_idx_b;

   logic         cur_in_ready, cur_out_valid, cur_rp_last, cur_rp_enc;
   logic [127:0] cur_out_block;
   logic [KW-1:0] cur_key_idx;

   logic [7:0]   sbox     [256];
   logic [7:0]   inv_sbox [256];
   logic [127:0] rk_a [16];
   logic [127:0] rk_b [16];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 Clk = ~Clk;

   aes_round_sequencer #(.NR(NR_A), .KIDX_W(KW)) dut_a (
      .Clk(Clk), .Rst_n(Rst_n),
      .In_valid(in_valid_a), .In_ready(in_ready_a), .In_encrypt(In_encrypt), .In_block(In_block),
      .Out_valid(out_valid_a), .Out_ready(Out_ready), .Out_block(out_block_a),
      .Key_idx(key_idx_a), .Key(key_a),
      .Rp_encrypt(rp_enc_a), .Rp_last(rp_last_a), .Rp_key(rp_key_a),
      .Rp_input_block(rp_in_a), .Rp_output_block(rp_out_a)
   );

   aes_round_sequencer #(.NR(NR_B), .KIDX_W(KW)) dut_b (
      .Clk(Clk), .Rst_n(Rst_n),
      .In_valid(in_valid_b), .In_ready(in_ready_b), .In_encrypt(In_encrypt), .In_block(In_block),
      .Out_valid(out_valid_b), .Out_ready(Out_ready), .Out_block(out_block_b),
      .Key_idx(key_idx_b), .Key(key_b),
      .Rp_encrypt(rp_enc_b), .Rp_last(rp_last_b), .Rp_key(rp_key_b),
      .Rp_input_block(rp_in_b), .Rp_output_block(rp_out_b)
   );

   // ---------------- AES reference arithmetic ----------------
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   // One AES round as the round port computes it: enc = SubBytes, ShiftRows,
   // MixColumns (not last), AddRoundKey; dec = InvShiftRows, InvSubBytes,
   // AddRoundKey, InvMixColumns (not last).
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic enc, input logic last);
      logic [7:0]   a [16];
      logic [7:0]   t [16];
      logic [7:0]   u [16];
      logic [7:0]   m [4];
      logic [127:0] v;
      for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[r+4*c] = enc ? sbox[a[r+4*((c+r)%4)]] : inv_sbox[a[r+4*((c-r+4)%4)]];
      if (!enc)
         for (int i = 0; i < 16; i++) t[i] = t[i] ^ k[127-8*i -: 8];
      if (enc) begin
         m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
      end else begin
         m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
      end
      if (!last) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
               u[r+4*c] = 8'h00;
               for (int j = 0; j < 4; j++)
                  u[r+4*c] = u[r+4*c] ^ gmul(m[(j-r+4)%4], t[j+4*c]);
            end
         for (int i = 0; i < 16; i++) t[i] = u[i];
      end
      for (int i = 0; i < 16; i++) v[127-8*i -: 8] = t[i];
      if (enc) v = v ^ k;
      return v;
   endfunction

   function automatic logic [127:0] rk_of(input logic sel, input int idx);
      return sel ? rk_b[idx] : rk_a[idx];
   endfunction

   // Whole-block reference cipher used for the randomised blocks.
   function automatic logic [127:0] aes_ref(input logic sel, input logic enc, input logic [127:0] blk);
      int nr;
      logic [127:0] s;
      nr = sel ? NR_B : NR_A;
      s  = blk ^ rk_of(sel, enc ? 0 : nr);
      for (int r = 1; r <= nr; r++)
         s = aes_round(s, rk_of(sel, enc ? r : nr - r), enc, r == nr);
      return s;
   endfunction

   task automatic buildTables();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x]     = s;
         inv_sbox[s] = 8'(x);
      end
   endtask

   task automatic expandKey(input logic [255:0] key, input int nk, input logic sel);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rcon;
      int nr;
      nr   = nk + 6;
      rcon = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
            rcon = xtime(rcon);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = sub_word(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int r = 0; r < 16; r++) begin
         if (r <= nr) begin
            if (sel) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else     rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         end else begin
            if (sel) rk_b[r] = '0;
            else     rk_a[r] = '0;
         end
      end
   endtask

   // Key stores and round ports around each sequencer.
   assign key_a    = rk_a[key_idx_a];
   assign key_b    = rk_b[key_idx_b];
   assign rp_out_a = aes_round(rp_in_a, rp_key_a, rp_enc_a, rp_last_a);
   assign rp_out_b = aes_round(rp_in_b, rp_key_b, rp_enc_b, rp_last_b);

   assign cur_in_ready  = cur_sel ? in_ready_b  : in_ready_a;
   assign cur_out_valid = cur_sel ? out_valid_b : out_valid_a;
   assign cur_out_block = cur_sel ? out_block_b : out_block_a;
   assign cur_key_idx   = cur_sel ? key_idx_b   : key_idx_a;
   assign cur_rp_last   = cur_sel ? rp_last_b   : rp_last_a;
   assign cur_rp_enc    = cur_sel ? rp_enc_b    : rp_enc_a;

   // ---------------- checking helpers ----------------
   task automatic checkValue(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Offers a block to the selected instance and returns at the handshake edge.
   task automatic applyStimulus(input logic sel, input logic enc, input logic [127:0] blk,
                                input logic hold, output time t_hs);
      int n;
      @(negedge Clk);
      cur_sel    = sel;
      In_encrypt = enc;
      In_block   = blk;
      if (sel) in_valid_b = 1'b1;
      else     in_valid_a = 1'b1;
      #1;
      n = 0;
      while (!cur_in_ready && n < 100) begin
         @(negedge Clk);
         #1;
         n++;
      end
      checkValue("in_ready_wait", 128'(cur_in_ready), 128'd1);
      checkValue("idle_key_idx", 128'(cur_key_idx), enc ? 128'd0 : (sel ? 128'(NR_B) : 128'(NR_A)));
      @(posedge Clk);
      t_hs = $time;
      #1;
      if (!hold) begin
         in_valid_a = 1'b0;
         in_valid_b = 1'b0;
      end
   endtask

   // Follows the rounds after a handshake: key index order, Last flag, mode,
   // latency to Out_valid and the result block.
   task automatic checkOutput(input logic sel, input logic enc, input logic [127:0] exp, input string name);
      int nr;
      int lat;
      logic seen;
      nr   = sel ? NR_B : NR_A;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < nr + 20) begin
         @(negedge Clk);
         lat++;
         if (cur_out_valid) begin
            seen = 1'b1;
         end else if (lat <= nr) begin
            checkValue({name, "_kidx"}, 128'(cur_key_idx), enc ? 128'(lat) : 128'(nr - lat));
            checkValue({name, "_last"}, 128'(cur_rp_last), 128'(lat == nr));
            checkValue({name, "_rpenc"}, 128'(cur_rp_enc), 128'(enc));
         end
      end
      checkValue({name, "_latency"}, 128'(lat), 128'(nr + 1));
      checkValue({name, "_block"}, cur_out_block, exp);
   endtask

   typedef struct {
      logic         sel;
      logic         enc;
      logic [127:0] blk;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs [4];

   initial begin
      time t_hs, t_prev;
      int  hits;
      logic enc;
      logic [127:0] blk;

      Rst_n      = 1'b0;
      In_encrypt = 1'b1;
      In_block   = '0;
      Out_ready  = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      cur_sel    = 1'b0;
      t_prev     = 0;
      buildTables();
      expandKey(KEY128, 4, 1'b0);
      expandKey(KEY256, 8, 1'b1);

      vecs[0] = '{sel: 1'b0, enc: 1'b1, blk: PT,    exp: CT128};
      vecs[1] = '{sel: 1'b0, enc: 1'b0, blk: CT128, exp: PT};
      vecs[2] = '{sel: 1'b1, enc: 1'b1, blk: PT,    exp: CT256};
      vecs[3] = '{sel: 1'b1, enc: 1'b0, blk: CT256, exp: PT};

      // Reset state
      repeat (3) @(negedge Clk);
      checkValue("rst_in_ready",  128'(in_ready_a),  128'd1);
      checkValue("rst_out_valid", 128'(out_valid_a), 128'd0);
      checkValue("rst_out_block", out_block_a,       128'd0);
      checkValue("rst_key_idx",   128'(key_idx_a),   128'd0);
      checkValue("rst_rp_last",   128'(rp_last_a),   128'd0);
      checkValue("rst_rp_enc",    128'(rp_enc_a),    128'd0);
      checkValue("rst_b_ready",   128'(in_ready_b),  128'd1);
      Rst_n = 1'b1;
      In_encrypt = 1'b0;
      #1;
      checkValue("idle_dec_kidx_a", 128'(key_idx_a), 128'(NR_A));
      checkValue("idle_dec_kidx_b", 128'(key_idx_b), 128'(NR_B));
      In_encrypt = 1'b1;
      hits = 0;
      repeat (4) begin
         @(negedge Clk);
         if (out_valid_a || !in_ready_a) hits++;
      end
      checkValue("idle_out_ready_ignored", 128'(hits), 128'd0);

      // FIPS-197 C.1 / C.3 vectors
      for (int i = 0; i < 4; i++) begin
         applyStimulus(vecs[i].sel, vecs[i].enc, vecs[i].blk, 1'b0, t_hs);
         checkOutput(vecs[i].sel, vecs[i].enc, vecs[i].exp, $sformatf("vec%0d", i));
         @(posedge Clk);
         #1;
         checkValue($sformatf("vec%0d_released", i), 128'(cur_out_valid), 128'd0);
         checkValue($sformatf("vec%0d_ready", i),    128'(cur_in_ready),  128'd1);
      end

      // Back-pressure with a second block offered throughout
      $display("[TB] back-pressure sequence");
      Out_ready = 1'b0;
      applyStimulus(1'b0, 1'b1, PT, 1'b1, t_hs);
      checkOutput(1'b0, 1'b1, CT128, "bp");
      In_encrypt = 1'b0;
      In_block   = CT128;
      for (int c = 0; c < 20; c++) begin
         @(negedge Clk);
         checkValue("bp_flags", {126'd0, out_valid_a, in_ready_a}, 128'b10);
         checkValue("bp_block", out_block_a, CT128);
      end
      Out_ready = 1'b1;
      @(posedge Clk);
      #1;
      checkValue("bp_drained", 128'(out_valid_a), 128'd0);
      applyStimulus(1'b0, 1'b0, CT128, 1'b0, t_hs);
      checkOutput(1'b0, 1'b0, PT, "bp_next");

      // Back-to-back random blocks with In_valid held
      $display("[TB] back-to-back sequence");
      for (int i = 0; i < 4; i++) begin
         enc = 1'($urandom_range(0, 1));
         blk = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(1'b0, enc, blk, 1'b1, t_hs);
         if (i > 0) checkValue($sformatf("b2b%0d_spacing", i), 128'((t_hs - t_prev) / 10), 128'(NR_A + 2));
         t_prev = t_hs;
         checkOutput(1'b0, enc, aes_ref(1'b0, enc, blk), $sformatf("b2b%0d", i));
      end
      @(negedge Clk);
      in_valid_a = 1'b0;
      @(negedge Clk);

      // Asynchronous reset during round 5
      $display("[TB] mid-block reset sequence");
      applyStimulus(1'b0, 1'b1, PT, 1'b0, t_hs);
      repeat (5) @(negedge Clk);
      #2;
      Rst_n = 1'b0;
      #1;
      checkValue("arst_in_ready",  128'(in_ready_a),  128'd1);
      checkValue("arst_out_valid", 128'(out_valid_a), 128'd0);
      checkValue("arst_rp_last",   128'(rp_last_a),   128'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      hits = 0;
      repeat (15) begin
         @(negedge Clk);
         if (out_valid_a) hits++;
      end
      checkValue("arst_no_output", 128'(hits), 128'd0);
      applyStimulus(1'b0, 1'b1, PT, 1'b0, t_hs);
      checkOutput(1'b0, 1'b1, CT128, "arst_next");

      repeat (2) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
